sddr_init_seq: RTL and testbench

SDDR_INIT_SEQ -- requirements
Module: sddr_init_seq

---
 rtl/sddr_pkg.sv | 46 ++++
 rtl/sddr_wait_counter.sv | 23 ++
 rtl/sddr_init_seq.sv | 183 ++++++++++++++++++
 tb/tb_sddr_init_seq.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sddr_pkg.sv
// Shared command encoding, init state enum and helpers for the SDDR init sequencer.
// SDDR_INIT_ZQCL_EN adds the ZQCL / ZQ_WAIT states to the enum.
package sddr_pkg;

  typedef struct packed {
    logic cs_n;
    logic ras_n;
    logic cas_n;
    logic we_n;
  } cmd_t;

  localparam cmd_t CMD_NOP   = '{cs_n: 1'b0, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1};
  localparam cmd_t CMD_MRS   = '{cs_n: 1'b0, ras_n: 1'b0, cas_n: 1'b0, we_n: 1'b0};
  localparam cmd_t CMD_ZQCL  = '{cs_n: 1'b0, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b0};
  localparam cmd_t CMD_DESEL = '{cs_n: 1'b1, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1};

  typedef enum logic [2:0] {
    RST_HOLD,
    CKE_WAIT,
    XPR_WAIT,
    MRS,
    MRS_WAIT,
`ifdef SDDR_INIT_ZQCL_EN
    ZQCL,
    ZQ_WAIT,
`endif
    DONE
  } init_state_t;

  localparam int NUM_MR = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Mode registers go out in the order MR2, MR3, MR1, MR0.
  function automatic logic [1:0] mr_ba(input logic [1:0] idx);
    case (idx)
      2'd0:    return 2'd2;
      2'd1:    return 2'd3;
      2'd2:    return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sddr_wait_counter.sv
// Loadable down-counter that saturates at zero and flags when it gets there.
module sddr_wait_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sddr_init_seq.sv
// SDDR power-up sequencer: reset/CKE timing, MR2/MR3/MR1/MR0 programming, then init_done.
// Define SDDR_INIT_ZQCL_EN to add a ZQCL calibration step before init_done.
module sddr_init_seq
  import sddr_pkg::*;
#(
  parameter int BANK_BITS    = 3,
  parameter int ROW_BITS     = 13,
  parameter int DATA_BITS    = 16,
  localparam int ADDR_W      = ROW_BITS + $clog2(DATA_BITS / 8),
  parameter int T_RESET_CYC  = 40000,
  parameter int T_CKE_CYC    = 100000,
  parameter int T_XPR_CYC    = 72,
  parameter int T_MRD_CYC    = 4,
  parameter int T_MOD_CYC    = 12,
  parameter int T_ZQINIT_CYC = 512,
  parameter logic [ADDR_W-1:0] MR0 = 'h0520,
  parameter logic [ADDR_W-1:0] MR1 = 'h0044,
  parameter logic [ADDR_W-1:0] MR2 = 'h0000,
  parameter logic [ADDR_W-1:0] MR3 = 'h0000
) (
  input  logic                 in_ddr_clock_i,
  input  logic                 in_ddr_reset_i,
  output logic                 ddr_reset_n_o,
  output logic                 ctl_cke_o,
  output logic                 ctl_cs_n_o,
  output logic                 ctl_ras_n_o,
  output logic                 ctl_cas_n_o,
  output logic                 ctl_we_n_o,
  output logic                 ctl_odt_o,
  output logic [ADDR_W-1:0]    ctl_addr_o,
  output logic [BANK_BITS-1:0] ctl_ba_o,
  output logic                 init_done_o
);

  localparam int T_MAX = max_int(max_int(max_int(T_RESET_CYC, T_CKE_CYC),
                                         max_int(T_XPR_CYC, T_MRD_CYC)),
                                 max_int(T_MOD_CYC, T_ZQINIT_CYC));
  localparam int CNT_W = $clog2(T_MAX) + 1;
`ifdef SDDR_INIT_ZQCL_EN
  localparam logic [ADDR_W-1:0] ZQ_ADDR = ADDR_W'(1 << 10);
`endif

  init_state_t         state_q, state_d;
  logic [2:0]          mr_idx_q, mr_idx_d;
  cmd_t                cmd_q, cmd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BANK_BITS-1:0] ba_q, ba_d;
  logic                rstn_q, rstn_d;
  logic                cke_q, cke_d;
  logic                done_q, done_d;
  logic                odt_q;
  logic                load_d;
  logic [CNT_W-1:0]    load_val_d;
  logic                cnt_zero;

  function automatic logic [ADDR_W-1:0] mr_value(input logic [1:0] idx);
    case (idx)
      2'd0:    return MR2;
      2'd1:    return MR3;
      2'd2:    return MR1;
      default: return MR0;
    endcase
  endfunction

  sddr_wait_counter #(.CNT_W(CNT_W)) u_wait_counter (
    .clk_i      (in_ddr_clock_i),
    .load_i     (in_ddr_reset_i | load_d),
    .load_val_i (in_ddr_reset_i ? CNT_W'(T_RESET_CYC) : load_val_d),
    .zero_o     (cnt_zero)
  );

  // Every wait-counter expiry either advances the state or issues the next command;
  // the counter is reloaded on the same edge so command spacing is exact.
  always_comb begin
    state_d    = state_q;
    mr_idx_d   = mr_idx_q;
    cmd_d      = CMD_NOP;
    addr_d     = '0;
    ba_d       = '0;
    rstn_d     = rstn_q;
    cke_d      = cke_q;
    done_d     = done_q;
    load_d     = 1'b0;
    load_val_d = '0;
    case (state_q)
      RST_HOLD: begin
        if (cnt_zero) begin
          state_d    = CKE_WAIT;
          rstn_d     = 1'b1;
          load_d     = 1'b1;
          load_val_d = CNT_W'(T_CKE_CYC - 1);
        end else begin
          cmd_d = CMD_DESEL;
        end
      end
      CKE_WAIT: begin
        if (cnt_zero) begin
          state_d    = XPR_WAIT;
          cke_d      = 1'b1;
          load_d     = 1'b1;
          load_val_d = CNT_W'(T_XPR_CYC - 1);
        end
      end
      XPR_WAIT, MRS, MRS_WAIT: begin
        if (!cnt_zero) begin
          state_d = MRS_WAIT;
        end else if (mr_idx_q != 3'(NUM_MR)) begin
          state_d    = MRS;
          cmd_d      = CMD_MRS;
          ba_d       = BANK_BITS'(mr_ba(mr_idx_q[1:0]));
          addr_d     = mr_value(mr_idx_q[1:0]);
          mr_idx_d   = mr_idx_q + 3'd1;
          load_d     = 1'b1;
          load_val_d = (mr_idx_q == 3'(NUM_MR - 1)) ? CNT_W'(T_MOD_CYC - 1)
                                                    : CNT_W'(T_MRD_CYC - 1);
        end else begin
`ifdef SDDR_INIT_ZQCL_EN
          state_d    = ZQCL;
          cmd_d      = CMD_ZQCL;
          addr_d     = ZQ_ADDR;
          load_d     = 1'b1;
          load_val_d = CNT_W'(T_ZQINIT_CYC - 1);
`else
          state_d = DONE;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef SDDR_INIT_ZQCL_EN
      ZQCL, ZQ_WAIT: begin
        if (cnt_zero) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ZQ_WAIT;
        end
      end
`endif
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = RST_HOLD;
      end
    endcase
  end

  always_ff @(posedge in_ddr_clock_i) begin
    if (in_ddr_reset_i) begin
      state_q  <= RST_HOLD;
      mr_idx_q <= '0;
      cmd_q    <= CMD_DESEL;
      addr_q   <= '0;
      ba_q     <= '0;
      rstn_q   <= 1'b0;
      cke_q    <= 1'b0;
      done_q   <= 1'b0;
      odt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mr_idx_q <= mr_idx_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      ba_q     <= ba_d;
      rstn_q   <= rstn_d;
      cke_q    <= cke_d;
      done_q   <= done_d;
      odt_q    <= 1'b0;
    end
  end

  assign ddr_reset_n_o = rstn_q;
  assign ctl_cke_o     = cke_q;
  assign ctl_cs_n_o    = cmd_q.cs_n;
  assign ctl_ras_n_o   = cmd_q.ras_n;
  assign ctl_cas_n_o   = cmd_q.cas_n;
  assign ctl_we_n_o    = cmd_q.we_n;
  assign ctl_odt_o     = odt_q;
  assign ctl_addr_o    = addr_q;
  assign ctl_ba_o      = ba_q;
  assign init_done_o   = done_q;

endmodule

// File: tb/tb_sddr_init_seq.sv
// Self-checking bench for sddr_init_seq: directed runs plus random reset aborts,
// every cycle compared against a timeline model derived from the init rules.
module tb_sddr_init_seq;

  localparam int TR   = 20;
  localparam int TC   = 50;
  localparam int TX   = 10;
  localparam int TMRD = 4;
  localparam int TMOD = 12;
  localparam int TZQ  = 32;
  localparam logic [13:0] MR0V = 14'h0520;
  localparam logic [13:0] MR1V = 14'h0044;
  localparam logic [13:0] MR2V = 14'h0218;
  localparam logic [13:0] MR3V = 14'h0004;

  localparam int T_MRS0 = TR + TC + TX;
  localparam int T_ZQ   = T_MRS0 + 3 * TMRD + TMOD;
`ifdef SDDR_INIT_ZQCL_EN
  localparam int T_DONE = T_ZQ + TZQ;
`else
  localparam int T_DONE = T_ZQ;
`endif
  localparam int RUN_LEN = T_DONE + 6;

  logic        clk;
  logic        ddrReset;
  logic        ddrResetN;
  logic        cke;
  logic        csN;
  logic        rasN;
  logic        casN;
  logic        weN;
  logic        odt;
  logic [13:0] addr;
  logic [2:0]  ba;
  logic        initDone;

  int assertCount;
  int failCount;
  int cyc;

  sddr_init_seq #(
    .BANK_BITS    (3),
    .ROW_BITS     (13),
    .DATA_BITS    (16),
    .T_RESET_CYC  (TR),
    .T_CKE_CYC    (TC),
    .T_XPR_CYC    (TX),
    .T_MRD_CYC    (TMRD),
    .T_MOD_CYC    (TMOD),
    .T_ZQINIT_CYC (TZQ),
    .MR0          (MR0V),
    .MR1          (MR1V),
    .MR2          (MR2V),
    .MR3          (MR3V)
  ) dut (
    .in_ddr_clock_i (clk),
    .in_ddr_reset_i (ddrReset),
    .ddr_reset_n_o  (ddrResetN),
    .ctl_cke_o      (cke),
    .ctl_cs_n_o     (csN),
    .ctl_ras_n_o    (rasN),
    .ctl_cas_n_o    (casN),
    .ctl_we_n_o     (weN),
    .ctl_odt_o      (odt),
    .ctl_addr_o     (addr),
    .ctl_ba_o       (ba),
    .init_done_o    (initDone)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected pins n cycles after reset release, packed as
  // {reset_n, cke, cs_n, ras_n, cas_n, we_n, odt, done, ba[2:0], addr[13:0]}.
  function automatic logic [24:0] model(input int n);
    logic [13:0] mrTab [4];
    logic [2:0]  baTab [4];
    logic [3:0]  cmdPins;
    logic [13:0] expAddr;
    logic [2:0]  expBa;
    mrTab   = '{MR2V, MR3V, MR1V, MR0V};
    baTab   = '{3'd2, 3'd3, 3'd1, 3'd0};
    cmdPins = (n < TR) ? 4'b1111 : 4'b0111;
    expAddr = '0;
    expBa   = '0;
    for (int k = 0; k < 4; k++) begin
      if (n == T_MRS0 + k * TMRD) begin
        cmdPins = 4'b0000;
        expAddr = mrTab[k];
        expBa   = baTab[k];
      end
    end
`ifdef SDDR_INIT_ZQCL_EN
    if (n == T_ZQ) begin
      cmdPins = 4'b0110;
      expAddr = 14'h0400;
    end
`endif
    return {(n >= TR), (n >= TR + TC), cmdPins, 1'b0, (n >= T_DONE), expBa, expAddr};
  endfunction

  localparam logic [24:0] RESET_EXP = {1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 3'd0, 14'd0};

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive reset for a number of cycles, checking every registered output after each edge.
  task automatic applyStimulus(input logic rstVal, input int cycles);
    logic        sampledReset;
    logic [24:0] expected;
    logic [24:0] observed;
    for (int i = 0; i < cycles; i++) begin
      ddrReset     = rstVal;
      sampledReset = ddrReset;
      @(posedge clk);
      #1;
      if (sampledReset) begin
        expected = RESET_EXP;
        cyc      = 0;
        observed = {ddrResetN, cke, csN, rasN, casN, weN, odt, initDone, ba, addr};
        checkOutput("reset_state", 32'(observed), 32'(expected));
      end else begin
        expected = model(cyc);
        observed = {ddrResetN, cke, csN, rasN, casN, weN, odt, initDone, ba, addr};
        checkOutput($sformatf("seq_cycle_%0d", cyc), 32'(observed), 32'(expected));
        cyc++;
      end
    end
  endtask

  initial begin
    int abortAt;
    int holdLen;
    assertCount = 0;
    failCount   = 0;
    cyc         = 0;
    ddrReset    = 1'b1;

    $display("[TB] reset hold");
    applyStimulus(1'b1, 3);

    $display("[TB] full sequence from release");
    applyStimulus(1'b0, RUN_LEN);

    $display("[TB] abort with one-cycle reset at cycle 86");
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 86);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, RUN_LEN);

    $display("[TB] random reset aborts");
    for (int t = 0; t < 4; t++) begin
      abortAt = $urandom_range(0, RUN_LEN);
      holdLen = $urandom_range(1, 3);
      applyStimulus(1'b0, abortAt);
      applyStimulus(1'b1, holdLen);
    end
    applyStimulus(1'b0, RUN_LEN);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
